// File: rtl/pomiar_obrotow.sv
// -----------------------------------------------------------------------------
// pomiar_obrotow -- encoder pulse-rate meter feeding zwracanie_digitow.
//
// Counts synchronised rising edges of the encoder input over a fixed gate
// window of GATE_CYCLES clocks. At each window close it publishes
// rpm = min(pulses * MNOZNIK, RPM_MAX) together with an overflow flag, and
// pulses rpm_valid for one cycle. rpm/przepelnienie hold between updates.
//
// Optional feature macro: DEBOUNCE_EN -- inserts a DEBOUNCE_CYCLES-deep
// level filter between the synchroniser and the edge detector.
//
// Ports:
//   clk            in   1  system clock
//   rst            in   1  synchronous reset, active-high
//   enkoder        in   1  raw encoder pulse, asynchronous to clk
//   wlacz          in   1  measurement enable
//   rpm            out  7  last measured speed, saturated to RPM_MAX
//   rpm_valid      out  1  one-cycle strobe, rpm updated this cycle
//   przepelnienie  out  1  last window saturated (scaled count > RPM_MAX)
// -----------------------------------------------------------------------------
module pomiar_obrotow #(
    parameter int GATE_CYCLES     = 1_000_000,
    parameter int MNOZNIK         = 1,
    parameter int RPM_MAX         = 99,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enkoder,
    input  logic       wlacz,
    output logic [6:0] rpm,
    output logic       rpm_valid,
    output logic       przepelnienie
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    // Wide enough that 256 * MNOZNIK never wraps for any sane scale factor.
    localparam int                SCALE_W   = 32;

    typedef enum logic [0:0] {
        STOP = 1'b0,
        LICZ = 1'b1
    } stan_t;

    // Saturating increment of the 8-bit pulse counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        logic [7:0] r;
        if (inc && (v != 8'hFF)) begin
            r = v + 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Clamp the scaled count to the display ceiling.
    function automatic logic [6:0] sat_rpm(input logic [SCALE_W-1:0] v);
        logic [6:0] r;
        if (v > SCALE_W'(RPM_MAX)) begin
            r = 7'(RPM_MAX);
        end else begin
            r = v[6:0];
        end
        return r;
    endfunction

    logic              sync1_r;
    logic              sync2_r;
    logic              level_s;
    logic [1:0]        mask_cnt_r;
    logic              prev_r;
    logic              edge_r;
    stan_t             state_r;
    stan_t             next_state_s;
    logic              close_s;
    logic [GATE_W-1:0] gate_cnt_r;
    logic [7:0]        pulse_cnt_r;
    logic [8:0]        total_s;
    logic [SCALE_W-1:0] scaled_s;
    logic [6:0]        rpm_r;
    logic              rpm_valid_r;
    logic              przep_r;

    // Two-flop synchroniser for the asynchronous encoder input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= enkoder;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic            filt_r;
    logic [DB_W-1:0] db_cnt_r;

    // Level filter: follow the synchronised input only after it has disagreed
    // for DEBOUNCE_CYCLES consecutive cycles. While edges are masked after
    // reset the filter tracks the input directly so a held level is absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r   <= 1'b0;
            db_cnt_r <= '0;
        end else if (mask_cnt_r != 2'd3) begin
            filt_r   <= sync2_r;
            db_cnt_r <= '0;
        end else if (sync2_r != filt_r) begin
            if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_r   <= sync2_r;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end else begin
            db_cnt_r <= '0;
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // Registered rising-edge detect, masked for three cycles after reset.
    // During the mask the history flop loads the pre-filter level, so an input
    // already high at reset release never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_cnt_r <= 2'd0;
            prev_r     <= 1'b0;
            edge_r     <= 1'b0;
        end else if (mask_cnt_r != 2'd3) begin
            mask_cnt_r <= mask_cnt_r + 2'd1;
            prev_r     <= sync2_r;
            edge_r     <= 1'b0;
        end else begin
            prev_r     <= level_s;
            edge_r     <= level_s & ~prev_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STOP;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and window-close decode.
    always_comb begin
        next_state_s = state_r;
        close_s      = 1'b0;
        case (state_r)
            STOP: begin
                if (wlacz) begin
                    next_state_s = LICZ;
                end else begin
                    next_state_s = STOP;
                end
            end
            LICZ: begin
                // A close still publishes even if wlacz drops on that cycle.
                close_s = (gate_cnt_r == GATE_LAST);
                if (!wlacz) begin
                    next_state_s = STOP;
                end else begin
                    next_state_s = LICZ;
                end
            end
            default: begin
                next_state_s = STOP;
            end
        endcase
    end

    // An edge on the closing cycle belongs to the closing window.
    assign total_s  = {1'b0, pulse_cnt_r} + {8'd0, edge_r};
    assign scaled_s = SCALE_W'(total_s) * SCALE_W'(MNOZNIK);

    // Gate and pulse counters; both restart on the close cycle itself so the
    // next window begins without a dead cycle, and clear when leaving LICZ.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt_r  <= '0;
            pulse_cnt_r <= 8'd0;
        end else if ((state_r == LICZ) && wlacz && !close_s) begin
            gate_cnt_r  <= gate_cnt_r + GATE_W'(1);
            pulse_cnt_r <= sat_inc(pulse_cnt_r, edge_r);
        end else begin
            gate_cnt_r  <= '0;
            pulse_cnt_r <= 8'd0;
        end
    end

    // Result registers: updated only at window close, strobe lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpm_r       <= 7'd0;
            przep_r     <= 1'b0;
            rpm_valid_r <= 1'b0;
        end else if (close_s) begin
            rpm_r       <= sat_rpm(scaled_s);
            przep_r     <= (scaled_s > SCALE_W'(RPM_MAX));
            rpm_valid_r <= 1'b1;
        end else begin
            rpm_valid_r <= 1'b0;
        end
    end

    assign rpm           = rpm_r;
    assign rpm_valid     = rpm_valid_r;
    assign przepelnienie = przep_r;

endmodule

// File: tb/tb_pomiar_obrotow.sv
// -----------------------------------------------------------------------------
// tb_pomiar_obrotow -- directed bench for pomiar_obrotow with GATE_CYCLES=100.
// Two instances share the stimulus: dut (MNOZNIK=1) and dut3 (MNOZNIK=3).
// A monitor records every strobe (cycle, rpm, overflow) of both instances;
// the main sequence compares those records against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pomiar_obrotow;

    localparam int G = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       enkoder;
    logic       wlacz;
    logic [6:0] rpm,  rpm3;
    logic       vld,  vld3;
    logic       ovf,  ovf3;

    pomiar_obrotow #(.GATE_CYCLES(G), .MNOZNIK(1), .RPM_MAX(99), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .enkoder(enkoder), .wlacz(wlacz),
        .rpm(rpm), .rpm_valid(vld), .przepelnienie(ovf)
    );

    pomiar_obrotow #(.GATE_CYCLES(G), .MNOZNIK(3), .RPM_MAX(99), .DEBOUNCE_CYCLES(4)) dut3 (
        .clk(clk), .rst(rst), .enkoder(enkoder), .wlacz(wlacz),
        .rpm(rpm3), .rpm_valid(vld3), .przepelnienie(ovf3)
    );

    always #5 clk = ~clk;

    // Count of rising clock edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int st_cyc[$];
    int st_rpm[$];
    int st_ovf[$];
    int st3_rpm[$];
    int st3_ovf[$];

    // Strobe recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (vld) begin
            st_cyc.push_back(cyc);
            st_rpm.push_back(int'(rpm));
            st_ovf.push_back(int'(ovf));
        end
        if (vld3) begin
            st3_rpm.push_back(int'(rpm3));
            st3_ovf.push_back(int'(ovf3));
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Periodic encoder generator (per==0 means hold low).
    int per = 0;
    int hi  = 0;
    int ph  = 0;

    task automatic step();
        @(negedge clk);
        if (per > 0) begin
            enkoder = (ph < hi);
            ph      = (ph + 1 == per) ? 0 : ph + 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int k, input int maxc, input string tag);
        int i = 0;
        while (st_cyc.size() < k && i < maxc) begin
            step();
            i++;
        end
        if (st_cyc.size() < k) chk(tag, st_cyc.size(), k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        wlacz   = 1'b0;
        per     = 0;
        ph      = 0;
        enkoder = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        st_cyc.delete();  st_rpm.delete();  st_ovf.delete();
        st3_rpm.delete(); st3_ovf.delete();
    endtask

    int w;
    int r;
    int n0;
    int p;

    initial begin
        rst     = 1'b1;
        wlacz   = 1'b0;
        enkoder = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rpm",   int'(rpm),  0);
        chk("reset_valid", int'(vld),  0);
        chk("reset_ovf",   int'(ovf),  0);
        chk("reset_rpm3",  int'(rpm3), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        st_cyc.delete(); st_rpm.delete(); st_ovf.delete();
        st3_rpm.delete(); st3_ovf.delete();

        // 1: 10 pulses per window, first strobe 101 cycles after wlacz rise.
        per = 10; hi = 5; ph = 0;
        wlacz = 1'b1;
        w = cyc;
        run_until(2, 300, "t1_timeout");
        chk("t1_latency", qat(st_cyc, 0) - w, 101);
        chk("t1_rpm",     qat(st_rpm, 0), 10);
        chk("t1_ovf",     qat(st_ovf, 0), 0);
        chk("t1_period",  qat(st_cyc, 1) - qat(st_cyc, 0), 100);
        chk("t1_rpm2",    qat(st_rpm, 1), 10);
        chk("t1_rpm_x3",  qat(st3_rpm, 0), 30);

        // 5: drop wlacz mid-window, nothing published, then a full window.
        run(60);
        wlacz = 1'b0;
        run(150);
        chk("t5_no_strobe", st_cyc.size(), 2);
        chk("t5_rpm_hold",  int'(rpm), 10);
        wlacz = 1'b1;
        w = cyc;
        run_until(3, 300, "t5_timeout");
        chk("t5_latency", qat(st_cyc, 2) - w, 101);
        chk("t5_rpm",     qat(st_rpm, 2), 10);

        // 2: 25 pulses (x3 = 75), then period-2 window (x3 saturates).
        do_reset();
        per = 4; hi = 2; ph = 0;
        wlacz = 1'b1;
        run_until(1, 300, "t2a_timeout");
        chk("t2_rpm_x3", qat(st3_rpm, 0), 75);
        chk("t2_ovf_x3", qat(st3_ovf, 0), 0);
        chk("t2_rpm_x1", qat(st_rpm, 0), 25);
        per = 2; hi = 1; ph = 0;
        run_until(2, 300, "t2b_timeout");
        chk("t2_sat_rpm_x3", qat(st3_rpm, 1), 99);
        chk("t2_sat_ovf_x3", qat(st3_ovf, 1), 1);
        chk("t2_ovf_x1",     qat(st_ovf, 1), 0);

        // 3: edges at gates 10,30,50,70 and exactly on closing gate 99.
        do_reset();
        wlacz = 1'b1;
        w = cyc;
        for (int i = 0; i < 205; i++) begin
            @(negedge clk);
            p = i + 3;   // gate at which a rise driven now reaches the counter
            enkoder = ((p >= 10 && p < 13) || (p >= 30 && p < 33) || (p >= 50 && p < 53) ||
                       (p >= 70 && p < 73) || (p >= 99 && p < 102));
        end
        chk("t3_close_edge_rpm", qat(st_rpm, 0), 5);
        chk("t3_next_rpm",       qat(st_rpm, 1), 0);

        // 4: reset in the middle of a window with the input held high.
        do_reset();
        per = 10; hi = 5; ph = 0;
        wlacz = 1'b1;
        run_until(1, 300, "t4_timeout");
        chk("t4_pre_rpm", qat(st_rpm, 0), 10);
        run(49);
        rst = 1'b1; per = 0; enkoder = 1'b1;
        @(negedge clk);
        chk("t4_rst_rpm",   int'(rpm), 0);
        chk("t4_rst_valid", int'(vld), 0);
        @(negedge clk);
        rst = 1'b0;
        r  = cyc;
        n0 = st_cyc.size();
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            enkoder = (i < 30) || (i >= 50 && i < 53) || (i >= 70 && i < 73);
        end
        chk("t4_latency", qat(st_cyc, n0) - r, 101);
        chk("t4_rpm",     qat(st_rpm, n0), 2);

        // 6: 3 clean pulses plus 8 two-cycle glitches per window.
        do_reset();
        wlacz = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            p = i % 100;
            enkoder = (p < 10) || (p >= 20 && p < 30) || (p >= 40 && p < 50) ||
                      (p >= 60 && p < 92 && ((p - 60) % 4) < 2);
        end
`ifdef DEBOUNCE_EN
        chk("t6_glitch_rpm", qat(st_rpm, 0), 3);
`else
        chk("t6_glitch_rpm", qat(st_rpm, 0), 11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
